// File: rtl/dircc_types_pkg.sv
// Shared dircc packet types plus the receiver framing constants and word-store helper.
package dircc_types_pkg;

  typedef struct packed {
    logic [31:0] hw_addr;
    logic [15:0] sw_addr;
    logic [6:0]  port;
    logic        flag;
  } address_t;

  typedef struct packed {
    address_t    dest;
    address_t    src;
    logic [31:0] lamport;
    logic [95:0] data;
  } packet_t;

  localparam int unsigned DIRCC_PACKET_WORDS = 8;
  localparam int unsigned DIRCC_HEADER_WORDS = 5;

  typedef enum logic [1:0] {IDLE, RECV, DROP} rx_state_t;

  // Address words carry their fields in [31:8]; the low byte is ignored.
  function automatic packet_t dircc_store_word(packet_t p, logic [2:0] idx, logic [31:0] w);
    packet_t r;
    r = p;
    case (idx)
      3'd0: r.dest.hw_addr = w;
      3'd1: {r.dest.sw_addr, r.dest.port, r.dest.flag} = w[31:8];
      3'd2: r.src.hw_addr = w;
      3'd3: {r.src.sw_addr, r.src.port, r.src.flag} = w[31:8];
      3'd4: r.lamport = w;
      default: r.data[32*(int'(idx) - int'(DIRCC_HEADER_WORDS)) +: 32] = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dircc_avalon_st_packet_receiver_fifo_fifo.sv
// Synchronous first-word-fall-through FIFO with level, full and empty outputs.
module dircc_packet_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign level_o = cnt_q;
  assign data_o  = empty_o ? '0 : mem_q[rd_q];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/dircc_avalon_st_packet_receiver_fifo.sv
// Reassembles 8-beat dircc packets from Avalon-ST, drops malformed framing, buffers in a FIFO.
module dircc_avalon_st_packet_receiver_fifo
  import dircc_types_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned DROP_CNT_WIDTH = 16,
  parameter bit          STRICT_EMPTY   = 1'b0
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        booting,
  input  logic [31:0]                 in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_sop,
  input  logic                        in_eop,
  input  logic [1:0]                  in_empty,
  output packet_t                     packet_data,
  output logic                        packet_valid,
  input  logic                        packet_ready,
  output logic                        receive_nearly_done,
  output logic                        receive_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        rx_error,
  output logic [DROP_CNT_WIDTH-1:0]   drop_count
);
  localparam logic [2:0] LAST_IDX = 3'(DIRCC_PACKET_WORDS - 1);

  rx_state_t                 state_q, state_d;
  logic [2:0]                idx_q, idx_d;
  packet_t                   pkt_q, pkt_d;
  logic                      done_q, err_q;
  logic [DROP_CNT_WIDTH-1:0] drop_q;
  logic                      push, err, accept, empty_ok;
  logic                      fifo_full, fifo_empty;
  logic [$bits(packet_t)-1:0] fifo_out;

  assign in_ready = reset_n && !booting && !fifo_full;
  assign accept   = in_valid && in_ready;
  assign empty_ok = !STRICT_EMPTY || (in_empty == 2'd0);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pkt_d   = pkt_q;
    push    = 1'b0;
    err     = 1'b0;
    if (accept) begin
      unique case (state_q)
        IDLE, DROP: begin
          if (in_sop && in_eop) begin
            err     = 1'b1;
            state_d = IDLE;
          end else if (in_sop) begin
            pkt_d   = dircc_store_word(pkt_q, 3'd0, in_data);
            idx_d   = 3'd1;
            state_d = RECV;
          end else begin
            err     = (state_q == IDLE);
            state_d = in_eop ? IDLE : DROP;
          end
        end
        RECV: begin
          // An sop mid-packet abandons the partial packet and restarts on this beat.
          if (in_sop) begin
            err = 1'b1;
            if (in_eop) begin
              state_d = IDLE;
            end else begin
              pkt_d = dircc_store_word(pkt_q, 3'd0, in_data);
              idx_d = 3'd1;
            end
          end else if (in_eop) begin
            state_d = IDLE;
            if (idx_q == LAST_IDX && empty_ok) begin
              pkt_d = dircc_store_word(pkt_q, idx_q, in_data);
              push  = 1'b1;
            end else begin
              err = 1'b1;
            end
          end else if (idx_q == LAST_IDX) begin
            err     = 1'b1;
            state_d = DROP;
          end else begin
            pkt_d = dircc_store_word(pkt_q, idx_q, in_data);
            idx_d = idx_q + 3'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pkt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pkt_q   <= pkt_d;
      done_q  <= push;
      err_q   <= err;
      if (err && drop_q != '1) drop_q <= drop_q + DROP_CNT_WIDTH'(1);
    end
  end

  dircc_packet_fifo #(
    .WIDTH ($bits(packet_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .push_i  (push),
    .data_i  (pkt_d),
    .pop_i   (packet_valid && packet_ready),
    .data_o  (fifo_out),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign packet_data         = packet_t'(fifo_out);
  assign packet_valid        = !fifo_empty;
  assign receive_nearly_done = (state_q == RECV) && (idx_q == LAST_IDX);
  assign receive_done        = done_q;
  assign rx_error            = err_q;
  assign drop_count          = drop_q;

endmodule

// File: tb/tb_dircc_avalon_st_packet_receiver_fifo.sv
// Scenario bench for the dircc Avalon-ST packet receiver FIFO with a packet scoreboard.
module tb_dircc_avalon_st_packet_receiver_fifo;
  import dircc_types_pkg::*;

  typedef struct {
    logic [31:0] d;
    logic        sop;
    logic        eop;
    logic [1:0]  empty;
  } beat_t;

  logic        clk, reset_n, booting;
  logic [31:0] in_data;
  logic        in_valid, in_ready, in_sop, in_eop;
  logic [1:0]  in_empty;
  packet_t     packet_data;
  logic        packet_valid, packet_ready;
  logic        receive_nearly_done, receive_done, rx_error;
  logic [2:0]  fifo_level;
  logic [1:0]  drop_count;

  beat_t   bfm[$];
  packet_t sb[$];
  int checks = 0, failures = 0;
  int done_cnt = 0, err_cnt = 0, pop_cnt = 0;

  dircc_avalon_st_packet_receiver_fifo #(
    .FIFO_DEPTH     (4),
    .DROP_CNT_WIDTH (2),
    .STRICT_EMPTY   (1'b0)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .booting             (booting),
    .in_data             (in_data),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .in_sop              (in_sop),
    .in_eop              (in_eop),
    .in_empty            (in_empty),
    .packet_data         (packet_data),
    .packet_valid        (packet_valid),
    .packet_ready        (packet_ready),
    .receive_nearly_done (receive_nearly_done),
    .receive_done        (receive_done),
    .fifo_level          (fifo_level),
    .rx_error            (rx_error),
    .drop_count          (drop_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Beat driver: present at negedge, decide acceptance just before the posedge.
  initial begin
    logic acc;
    in_valid = 1'b0; in_data = '0; in_sop = 1'b0; in_eop = 1'b0; in_empty = '0;
    forever begin
      @(negedge clk);
      if (bfm.size() > 0) begin
        in_valid = 1'b1; in_data = bfm[0].d; in_sop = bfm[0].sop;
        in_eop = bfm[0].eop; in_empty = bfm[0].empty;
      end else begin
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
      end
      #4;
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) void'(bfm.pop_front());
    end
  end

  // Output monitor and scoreboard comparison.
  initial begin
    packet_t exp;
    forever begin
      @(negedge clk);
      #4;
      if (receive_done === 1'b1) done_cnt++;
      if (rx_error === 1'b1) err_cnt++;
      if (packet_valid === 1'b1 && packet_ready === 1'b1) begin
        pop_cnt++;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL pop_unexpected got=%h exp=none", packet_data);
        end else begin
          exp = sb.pop_front();
          if (packet_data !== exp) begin
            failures++;
            $display("FAIL pop_data got=%h exp=%h", packet_data, exp);
          end
        end
      end
    end
  end

  function automatic packet_t rand_pkt();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return packet_t'(v[$bits(packet_t)-1:0]);
  endfunction

  function automatic logic [31:0] pkt_word(packet_t p, int i);
    case (i)
      0: return p.dest.hw_addr;
      1: return {p.dest.sw_addr, p.dest.port, p.dest.flag, 8'hA5};
      2: return p.src.hw_addr;
      3: return {p.src.sw_addr, p.src.port, p.src.flag, 8'h5A};
      4: return p.lamport;
      5: return p.data[31:0];
      6: return p.data[63:32];
      7: return p.data[95:64];
      default: return $urandom;
    endcase
  endfunction

  task automatic send_words(input packet_t p, input int n, input int eop_at, input logic [1:0] emp);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.d = pkt_word(p, i); b.sop = (i == 0); b.eop = (i == eop_at);
      b.empty = (i == eop_at) ? emp : 2'd0;
      bfm.push_back(b);
    end
  endtask

  task automatic send_good(input packet_t p, input logic [1:0] emp);
    send_words(p, 8, 7, emp);
    sb.push_back(p);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_bfm(input int target, input int max_cyc, input string tag);
    int n = 0;
    while (bfm.size() > target && n < max_cyc) begin @(negedge clk); n++; end
    if (bfm.size() > target) begin
      checks++; failures++;
      $display("FAIL %s_timeout got=%0d beats exp<=%0d", tag, bfm.size(), target);
    end
  endtask

  task automatic wait_empty_fifo(input int max_cyc, input string tag);
    int n = 0;
    while (fifo_level != 0 && n < max_cyc) begin @(negedge clk); n++; end
    if (fifo_level != 0) begin
      checks++; failures++;
      $display("FAIL %s_drain_timeout got=%0d exp=0", tag, fifo_level);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    bfm.delete(); sb.delete();
    cycles(10);
    reset_n = 1'b1;
    done_cnt = 0; err_cnt = 0; pop_cnt = 0;
  endtask

  task automatic test_reset();
    packet_t p;
    cycles(2);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    checks++; if (packet_data !== '0) begin failures++; $display("FAIL rst_data got=%h exp=0", packet_data); end
    reset_n = 1'b1;
    p = rand_pkt();
    send_words(p, 4, -1, 2'd0);
    wait_bfm(0, 50, "rst_mid");
    do_reset();
    cycles(10);
    checks++; if (packet_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", packet_valid); end
    checks++; if (receive_nearly_done !== 1'b0) begin failures++; $display("FAIL rst_nearly got=%b exp=0", receive_nearly_done); end
    checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL rst_level got=%0d exp=0", fifo_level); end
    checks++; if (drop_count !== 2'd0) begin failures++; $display("FAIL rst_drop got=%0d exp=0", drop_count); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_ready_after got=%b exp=1", in_ready); end
    checks++; if (rx_error !== 1'b0 || receive_done !== 1'b0) begin failures++; $display("FAIL rst_pulses got=%b%b exp=00", rx_error, receive_done); end
  endtask

  task automatic test_single();
    packet_t p;
    packet_ready = 1'b0;
    p = rand_pkt();
    p.data[95:64] = 32'hDEADBEEF;
    send_good(p, 2'd0);
    wait_bfm(0, 50, "single");
    checks++; if (packet_valid !== 1'b1) begin failures++; $display("FAIL single_latency got=%b exp=1", packet_valid); end
    cycles(3);
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL single_done got=%0d exp=1", done_cnt); end
    checks++; if (fifo_level !== 3'd1) begin failures++; $display("FAIL single_level got=%0d exp=1", fifo_level); end
    checks++; if (packet_data !== p) begin failures++; $display("FAIL single_data got=%h exp=%h", packet_data, p); end
    checks++; if (packet_data.data[95:64] !== 32'hDEADBEEF) begin failures++; $display("FAIL single_w7 got=%h exp=deadbeef", packet_data.data[95:64]); end
    packet_ready = 1'b1;
    wait_empty_fifo(20, "single");
    packet_ready = 1'b0;
    cycles(2);
    checks++; if (pop_cnt !== 1) begin failures++; $display("FAIL single_pops got=%0d exp=1", pop_cnt); end
  endtask

  task automatic test_backpressure();
    done_cnt = 0; pop_cnt = 0;
    packet_ready = 1'b0;
    for (int k = 0; k < 5; k++) send_good(rand_pkt(), 2'd0);
    wait_bfm(8, 200, "bp_fill");
    cycles(3);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready got=%b exp=0", in_ready); end
    checks++; if (fifo_level !== 3'd4) begin failures++; $display("FAIL bp_level got=%0d exp=4", fifo_level); end
    checks++; if (bfm.size() !== 8) begin failures++; $display("FAIL bp_held got=%0d exp=8", bfm.size()); end
    packet_ready = 1'b1;
    @(negedge clk);
    packet_ready = 1'b0;
    wait_bfm(0, 50, "bp_fifth");
    cycles(3);
    checks++; if (fifo_level !== 3'd4 || done_cnt !== 5) begin failures++; $display("FAIL bp_refill got=%0d/%0d exp=4/5", fifo_level, done_cnt); end
    packet_ready = 1'b1;
    wait_empty_fifo(20, "bp");
    packet_ready = 1'b0;
    cycles(2);
    checks++; if (pop_cnt !== 5 || sb.size() !== 0) begin failures++; $display("FAIL bp_pops got=%0d/%0d exp=5/0", pop_cnt, sb.size()); end
  endtask

  task automatic test_back_to_back();
    pop_cnt = 0; done_cnt = 0;
    packet_ready = 1'b0;
    for (int k = 0; k < 3; k++) send_good(rand_pkt(), 2'd0);
    wait_bfm(1, 200, "b2b");
    packet_ready = 1'b1;
    @(negedge clk);
    packet_ready = 1'b0;
    checks++; if (fifo_level !== 3'd2) begin failures++; $display("FAIL b2b_level got=%0d exp=2", fifo_level); end
    packet_ready = 1'b1;
    wait_empty_fifo(20, "b2b");
    packet_ready = 1'b0;
    cycles(2);
    checks++; if (pop_cnt !== 3 || done_cnt !== 3) begin failures++; $display("FAIL b2b_counts got=%0d/%0d exp=3/3", pop_cnt, done_cnt); end
  endtask

  task automatic test_partial();
    done_cnt = 0; err_cnt = 0;
    send_words(rand_pkt(), 7, -1, 2'd0);
    wait_bfm(0, 50, "partial");
    cycles(3);
    checks++; if (receive_nearly_done !== 1'b1) begin failures++; $display("FAIL partial_nearly got=%b exp=1", receive_nearly_done); end
    checks++; if (packet_valid !== 1'b0 || done_cnt !== 0) begin failures++; $display("FAIL partial_out got=%b/%0d exp=0/0", packet_valid, done_cnt); end
    do_reset();
    cycles(1);
    checks++; if (receive_nearly_done !== 1'b0) begin failures++; $display("FAIL partial_rst got=%b exp=0", receive_nearly_done); end
  endtask

  task automatic test_malformed();
    beat_t b;
    packet_ready = 1'b1;
    done_cnt = 0; err_cnt = 0; pop_cnt = 0;
    send_words(rand_pkt(), 4, 3, 2'd0);
    send_good(rand_pkt(), 2'd1);
    send_words(rand_pkt(), 5, -1, 2'd0);
    send_good(rand_pkt(), 2'd0);
    send_words(rand_pkt(), 10, 9, 2'd0);
    send_good(rand_pkt(), 2'd0);
    wait_bfm(0, 400, "malformed");
    cycles(4);
    checks++; if (err_cnt !== 3) begin failures++; $display("FAIL mal_errors got=%0d exp=3", err_cnt); end
    checks++; if (drop_count !== 2'd3) begin failures++; $display("FAIL mal_drop got=%0d exp=3", drop_count); end
    checks++; if (done_cnt !== 3 || pop_cnt !== 3 || sb.size() !== 0) begin failures++; $display("FAIL mal_good got=%0d/%0d/%0d exp=3/3/0", done_cnt, pop_cnt, sb.size()); end
    b.d = 32'h1234_5678; b.sop = 1'b0; b.eop = 1'b1; b.empty = 2'd0;
    bfm.push_back(b);
    wait_bfm(0, 20, "sat");
    cycles(3);
    checks++; if (err_cnt !== 4 || drop_count !== 2'd3) begin failures++; $display("FAIL drop_saturate got=%0d/%0d exp=4/3", err_cnt, drop_count); end
    packet_ready = 1'b0;
  endtask

  task automatic test_boot();
    logic any_ready;
    do_reset();
    packet_ready = 1'b0;
    send_good(rand_pkt(), 2'd0);
    wait_bfm(4, 50, "boot_mid");
    booting = 1'b1;
    cycles(10);
    checks++; if (bfm.size() !== 4 || packet_valid !== 1'b0) begin failures++; $display("FAIL boot_hold got=%0d/%b exp=4/0", bfm.size(), packet_valid); end
    booting = 1'b0;
    wait_bfm(0, 50, "boot_resume");
    cycles(2);
    checks++; if (fifo_level !== 3'd1) begin failures++; $display("FAIL boot_resume got=%0d exp=1", fifo_level); end
    packet_ready = 1'b1;
    wait_empty_fifo(20, "boot_a");
    packet_ready = 1'b0;
    booting = 1'b1;
    for (int k = 0; k < 5; k++) send_good(rand_pkt(), 2'd0);
    any_ready = 1'b0;
    repeat (30) begin @(negedge clk); #1; if (in_ready !== 1'b0) any_ready = 1'b1; end
    checks++; if (any_ready !== 1'b0 || bfm.size() !== 40) begin failures++; $display("FAIL boot_stall got=%b/%0d exp=0/40", any_ready, bfm.size()); end
    @(negedge clk);
    booting = 1'b0;
    wait_bfm(8, 300, "boot_fill");
    cycles(3);
    checks++; if (fifo_level !== 3'd4 || in_ready !== 1'b0 || bfm.size() !== 8) begin failures++; $display("FAIL boot_fill got=%0d/%b/%0d exp=4/0/8", fifo_level, in_ready, bfm.size()); end
    packet_ready = 1'b1;
    wait_bfm(0, 100, "boot_tail");
    wait_empty_fifo(20, "boot_b");
    cycles(2);
    checks++; if (pop_cnt !== 6 || sb.size() !== 0) begin failures++; $display("FAIL boot_pops got=%0d/%0d exp=6/0", pop_cnt, sb.size()); end
    packet_ready = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; booting = 1'b0; packet_ready = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_partial();
    test_malformed();
    test_boot();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dircc_avalon_st_packet_receiver_fifo.md
Name: dircc_avalon_st_packet_receiver_fifo

Overview:
Parametrised successor to the single-packet Avalon-ST receiver. It reassembles 8-word dircc packets (32-bit beats) from the router-side Avalon-ST sink into packet_t and buffers up to FIFO_DEPTH complete packets. It presents them to the core through a valid/ready handshake. It also detects and drops malformed framing, so a bad upstream packet never reaches the softcore mailbox.

Parameters:
FIFO_DEPTH, 4, number of complete packets buffered; power of two, at least 2.
DROP_CNT_WIDTH, 16, width of the saturating dropped-packet counter.
STRICT_EMPTY, 0, when 1 an eop beat with nonzero in_empty is malformed.

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
booting  in  1  high = node booting; forces in_ready low
in_data  in  32  Avalon-ST sink data
in_valid  in  1  sink valid
in_ready  out  1  sink ready (readyLatency 0)
in_sop  in  1  start of packet
in_eop  in  1  end of packet
in_empty  in  2  empty symbols on eop beat
packet_data  out  $bits(packet_t)  head-of-FIFO packet
packet_valid  out  1  head packet available
packet_ready  in  1  consumer accepts head packet
receive_nearly_done  out  1  assembler holds 7 words and is waiting for the eop beat
receive_done  out  1  one-cycle pulse per committed packet
fifo_level  out  $clog2(FIFO_DEPTH)+1  packets held
rx_error  out  1  one-cycle pulse per framing error
drop_count  out  DROP_CNT_WIDTH  saturating count of dropped packets

Behaviour:
- Beat is accepted when in_valid && in_ready. in_ready = !booting && (fifo_level < FIFO_DEPTH), registered from current state. A pop in the same cycle does not raise in_ready in that cycle.
- Word map, in beat order:
  - w0: dest.hw_addr.
  - w1: {dest.sw_addr, dest.port, dest.flag} in bits [31:8]; bits [7:0] are ignored.
  - w2: src.hw_addr.
  - w3: src fields, packed as w1.
  - w4: lamport.
  - w5: data[31:0]; w6: data[63:32]; w7: data[95:64].
- Assembler FSM states: IDLE, RECV (word index 1..7), DROP.
  - IDLE, sop beat: store w0, go to RECV with index 1.
  - IDLE, non-sop beat: discard it, pulse rx_error, go to DROP unless the beat has eop.
  - RECV, normal beat: store word at index, then increment index.
  - RECV, index 7 with eop (and empty ok): commit, go to IDLE.
  - RECV, eop with index < 7: drop, rx_error, go to IDLE.
  - RECV, index 7 without eop: drop, rx_error, go to DROP.
  - RECV, sop beat: drop the partial packet, rx_error, restart at index 1 storing the beat as w0.
  - DROP: discard beats until an eop beat, then go to IDLE. An sop beat in DROP behaves as in IDLE.
- Commit: the packet is written into the FIFO on the clock edge that accepts w7. receive_done pulses in the following cycle.
- Latency: if the FIFO was empty, packet_valid rises 1 cycle after the w7 beat is accepted.
- Output handshake: head packet pops on packet_valid && packet_ready. packet_data stays stable while packet_valid && !packet_ready.
- Simultaneous push and pop: fifo_level is unchanged; FIFO order is preserved.
- receive_nearly_done is high while in RECV with index 7.
- Each dropped packet increments drop_count once; the count saturates at all-ones.
- booting only gates in_ready. A packet partly assembled when booting rises resumes when booting falls.
- Reset (reset_n=0 at a clk edge), including mid-packet:
  - FSM goes to IDLE and the FIFO empties.
  - in_ready=0, packet_valid=0, receive_done=0, receive_nearly_done=0, rx_error=0, fifo_level=0, drop_count=0.
  - packet_data=0.

Decomposition:
- Extend dircc_types_pkg with: DIRCC_PACKET_WORDS=8, DIRCC_HEADER_WORDS=5, typedef rx_state_t {IDLE, RECV, DROP}.
- packet_t and address_t stay in dircc_types_pkg unchanged.
- One sub-module, dircc_packet_fifo: synchronous FIFO parametrised by WIDTH and DEPTH, with first-word fall-through, level output and full/empty outputs.

Test Plan:
- Reset mid-packet: send w0..w3, assert reset_n=0 for 10 clk, release, wait 10 clk -> packet_valid=0, receive_nearly_done=0, fifo_level=0, drop_count=0, in_ready=1.
- Single packet, packet_ready=0: send random packet, w7 data 32'hDEADBEEF -> receive_done pulses once, packet_valid=1, fifo_level=1, packet_data equals the sent packet field for field.
- Backpressure, FIFO_DEPTH=4, packet_ready=0: send 5 packets -> in_ready=0 after the 4th commit, fifo_level=4, 5th packet held in the BFM queue. Then packet_ready=1 for 1 cycle -> the 5th packet is accepted, all 5 pop in order.
- Partial packet: send w0..w6 only -> receive_nearly_done=1, receive_done never pulses, packet_valid=0.
- Malformed framing, each followed by a good packet:
  - eop on w3;
  - sop re-asserted on w5;
  - w7 sent without eop, then 2 extra beats ending in eop.
  - Required: rx_error pulses exactly 3 times, drop_count=3, only the good packets appear at the output.
- Boot stall: booting=1, push 5 packets -> in_ready=0 throughout, BFM queue size 40. booting=0, packet_ready=0 -> 4 packets committed, in_ready=0, BFM queue size 8.
